seven_segment_decoder: RTL and testbench

SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

---
 rtl/seven_segment_decoder.sv | 140 ++++++++++++++
 tb/tb_seven_segment_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// Debounced seven-segment pattern decoder: synchronizes active-low segment lines,
// waits for a pattern to hold STABLE_CYCLES cycles, then reports digit/error/blank.
module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Digit,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank,
  output logic [7:0] o_Change_Count
);

  typedef enum logic {LOCKED, SETTLE} state_t;

  localparam logic [7:0] LAST_N = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] FULL_N = 8'(STABLE_CYCLES);

  logic [6:0] pat;
  logic [6:0] sync1_q, seg_q;
  logic [6:0] cand_q, cand_d;
  logic [6:0] acc_q, acc_d;
  logic [7:0] n_q, n_d;
  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       blank_q, blank_d;
  logic [7:0] count_q, count_d;
  logic [4:0] dec;

  // {in_table, digit}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E:   return {1'b1, 4'd0};
      7'h30:   return {1'b1, 4'd1};
      7'h6D:   return {1'b1, 4'd2};
      7'h79:   return {1'b1, 4'd3};
      7'h33:   return {1'b1, 4'd4};
      7'h5B:   return {1'b1, 4'd5};
      7'h5F:   return {1'b1, 4'd6};
      7'h70:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h7B:   return {1'b1, 4'd9};
      7'h47:   return {1'b1, 4'd10};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pat = ~{i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                 i_Segment_E, i_Segment_F, i_Segment_G};
  assign dec = decode(cand_q);

  always_comb begin
    cand_d  = cand_q;
    acc_d   = acc_q;
    n_d     = n_q;
    state_d = state_q;
    digit_d = digit_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    blank_d = blank_q;
    count_d = count_q;
    if (seg_q != cand_q) begin
      cand_d  = seg_q;
      n_d     = 8'd1;
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      // The capture cycle counts as the first stable cycle, so accept on the last one.
      if (n_q >= LAST_N) begin
        n_d     = FULL_N;
        state_d = LOCKED;
        acc_d   = cand_q;
        if (cand_q != acc_q) begin
          if (cand_q == 7'h00) begin
            blank_d = 1'b1;
          end else begin
            blank_d = 1'b0;
            if (dec[4]) begin
              digit_d = dec[3:0];
              valid_d = 1'b1;
              count_d = sat_inc(count_q);
            end else begin
              error_d = 1'b1;
            end
          end
        end
      end else begin
        n_d = n_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      seg_q   <= '0;
      cand_q  <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      state_q <= LOCKED;
      digit_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      blank_q <= 1'b1;
      count_q <= '0;
    end else begin
      sync1_q <= pat;
      seg_q   <= sync1_q;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      error_q <= error_d;
      blank_q <= blank_d;
      count_q <= count_d;
    end
  end

  assign o_Digit        = digit_q;
  assign o_Valid        = valid_q;
  assign o_Error        = error_q;
  assign o_Blank        = blank_q;
  assign o_Change_Count = count_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: directed and random segment patterns compared
// each cycle against a run-length reference model of the debounce/decode behaviour.
module tb_seven_segment_decoder;

  localparam int SC = 4;
  localparam logic [6:0] TBL [0:10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                        7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h47};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] pat_drv = 7'h00;
  logic [6:0] seg_n;
  logic [3:0] digit;
  logic       valid, error, blank;
  logic [7:0] count;

  assign seg_n = ~pat_drv;

  seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Segment_A    (seg_n[6]),
    .i_Segment_B    (seg_n[5]),
    .i_Segment_C    (seg_n[4]),
    .i_Segment_D    (seg_n[3]),
    .i_Segment_E    (seg_n[2]),
    .i_Segment_F    (seg_n[1]),
    .i_Segment_G    (seg_n[0]),
    .o_Digit        (digit),
    .o_Valid        (valid),
    .o_Error        (error),
    .o_Blank        (blank),
    .o_Change_Count (count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_vpulse = 0;
  int n_epulse = 0;
  logic prev_pulse = 1'b0;

  // Reference model: two-edge input delay, then a run length over the seen pattern.
  logic [6:0] m_s1, m_s2, run_val, m_acc;
  int         run_len;
  logic [3:0] m_digit;
  logic       m_valid, m_err, m_blank;
  logic [7:0] m_cnt;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i <= 10; i++) if (TBL[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = 7'h00; m_s2 = 7'h00; run_val = 7'h00; run_len = SC;
    m_acc = 7'h00; m_digit = 4'd0; m_valid = 1'b0; m_err = 1'b0;
    m_blank = 1'b1; m_cnt = 8'd0; prev_pulse = 1'b0;
  endtask

  task automatic model_edge();
    logic [6:0] s;
    int idx;
    s = m_s2; m_s2 = m_s1; m_s1 = pat_drv;
    m_valid = 1'b0; m_err = 1'b0;
    if (s != run_val) begin
      run_val = s; run_len = 1;
    end else if (run_len < SC) begin
      run_len++;
      if (run_len == SC && run_val != m_acc) begin
        m_acc = run_val;
        if (run_val == 7'h00) m_blank = 1'b1;
        else begin
          m_blank = 1'b0;
          idx = lookup(run_val);
          if (idx >= 0) begin
            m_digit = 4'(idx); m_valid = 1'b1;
            if (m_cnt != 8'd255) m_cnt++;
          end else m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("digit", {4'd0, digit}, {4'd0, m_digit});
    chk("valid", {7'd0, valid}, {7'd0, m_valid});
    chk("error", {7'd0, error}, {7'd0, m_err});
    chk("blank", {7'd0, blank}, {7'd0, m_blank});
    chk("count", count, m_cnt);
    chk("pulse_excl", {6'd0, valid & error, prev_pulse & (valid | error)}, 8'd0);
    prev_pulse = valid | error;
    if (valid) n_vpulse++;
    if (error) n_epulse++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    pat_drv = p;
    repeat (n) tick();
  endtask

  // Asserts reset between edges, checks the immediate effect, releases between edges.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_digit", {4'd0, digit}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_error", {7'd0, error}, 8'd0);
    chk("rst_blank", {7'd0, blank}, 8'd1);
    chk("rst_count", count, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, v0, e0, kind, len;
    logic [6:0] p;
    model_reset();

    // Reset, then a held 0 pattern and its latency.
    do_reset();
    pat_drv = 7'h7E;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid && lat == 0) lat = i;
    end
    chk("latency", 8'(lat), 8'd6);
    chk("first_digit", {4'd0, digit}, 8'd0);
    chk("first_blank", {7'd0, blank}, 8'd0);
    chk("first_count", count, 8'd1);

    // Sweep of every table entry.
    do_reset();
    v0 = n_vpulse;
    for (int i = 0; i <= 10; i++) begin
      hold(TBL[i], 10);
      chk("sweep_digit", {4'd0, digit}, 8'(i));
    end
    chk("sweep_pulses", 8'(n_vpulse - v0), 8'd11);
    chk("sweep_count", count, 8'd11);

    // Short glitch back to the prior pattern.
    hold(7'h30, 10);
    v0 = n_vpulse; e0 = n_epulse;
    hold(7'h6D, 3);
    hold(7'h30, 10);
    chk("glitch_pulses", 8'(n_vpulse - v0 + n_epulse - e0), 8'd0);
    chk("glitch_digit", {4'd0, digit}, 8'd1);

    // Invalid pattern, then all segments off.
    v0 = n_vpulse; e0 = n_epulse;
    hold(7'h01, 10);
    chk("inv_err_pulses", 8'(n_epulse - e0), 8'd1);
    chk("inv_digit", {4'd0, digit}, 8'd1);
    hold(7'h00, 10);
    chk("blank_level", {7'd0, blank}, 8'd1);
    chk("blank_pulses", 8'(n_vpulse - v0 + n_epulse - e0), 8'd1);

    // Random patterns and hold lengths, including sub-threshold glitches.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 8);
      if (kind <= 1) p = TBL[$urandom_range(0, 10)];
      else if (kind == 2) p = 7'($urandom);
      else p = 7'h00;
      hold(p, len);
    end

    // Counter saturation.
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h7F : 7'h47, 6);
    chk("sat_count", count, 8'd255);

    // Reset in the middle of settling, pattern left on the inputs afterwards.
    hold(7'h30, 10);
    v0 = n_vpulse; e0 = n_epulse;
    hold(7'h79, 3);
    do_reset();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid && lat == 0) lat = i;
    end
    chk("post_rst_latency", 8'(lat), 8'd6);
    chk("post_rst_digit", {4'd0, digit}, 8'd3);
    chk("post_rst_pulses", 8'(n_vpulse - v0 + n_epulse - e0), 8'd1);
    chk("post_rst_count", count, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
